// File: rtl/hazard_stall_pkg.sv
// Shared pipeline-control types for the hazard stall controller.
// Optional perf counters are enabled with HAZARD_PERF_CNT_EN.
package hazard_stall_pkg;

    localparam int REG_ADDR_W_DEF = 5;
    localparam int ZERO_REG       = 0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_write;
        logic idex_bubble;
        logic exmem_write;
        logic memwb_bubble;
        logic pc_redirect;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_OFF    = '0;
    localparam hz_ctrl_t CTRL_RUN    = 8'b1101_0100;
    localparam hz_ctrl_t CTRL_STALL  = 8'b0001_1100;
    localparam hz_ctrl_t CTRL_BRANCH = 8'b1111_1101;
    localparam hz_ctrl_t CTRL_FREEZE = 8'b0000_0010;

endpackage

// File: rtl/hazard_stall_controller_perf.sv
// Saturating event counters for load-use bubbles, flushes and freezes.
// Instantiated only when HAZARD_PERF_CNT_EN is defined.
module hazard_perf_counters (
    input  logic        clk,
    input  logic        rst,
    input  logic        lu_bubble_i,
    input  logic        flush_i,
    input  logic        freeze_i,
    output logic [31:0] perf_lu_bubbles_o,
    output logic [31:0] perf_flushes_o,
    output logic [31:0] perf_freeze_cycles_o
);

    logic [31:0] lu_q, fl_q, fz_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lu_q <= '0;
            fl_q <= '0;
            fz_q <= '0;
        end else begin
            if (lu_bubble_i && lu_q != '1) lu_q <= lu_q + 32'd1;
            if (flush_i && fl_q != '1)     fl_q <= fl_q + 32'd1;
            if (freeze_i && fz_q != '1)    fz_q <= fz_q + 32'd1;
        end
    end

    assign perf_lu_bubbles_o    = lu_q;
    assign perf_flushes_o       = fl_q;
    assign perf_freeze_cycles_o = fz_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// Load-use / branch-flush / memory-freeze sequencing for the 5-stage core.
// Define HAZARD_PERF_CNT_EN to add the perf_* event counters.
module hazard_stall_controller
    import hazard_stall_pkg::*;
#(
    parameter int REG_ADDR_W        = REG_ADDR_W_DEF,
    parameter int LOAD_STALL_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] ifid_reg_rs,
    input  logic [REG_ADDR_W-1:0] ifid_reg_rt,
    input  logic                  ifid_uses_rt,
    input  logic                  idex_mem_read,
    input  logic [REG_ADDR_W-1:0] idex_reg_rt,
    input  logic                  exmem_branch_taken,
    input  logic                  exmem_mem_req,
    input  logic                  dmem_ready,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  idex_write,
    output logic                  idex_bubble,
    output logic                  exmem_write,
    output logic                  memwb_bubble,
    output logic                  pc_redirect
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           perf_lu_bubbles,
    output logic [31:0]           perf_flushes,
    output logic [31:0]           perf_freeze_cycles
`endif
);

    localparam logic [2:0] LU_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
    localparam bit         LU_MULTI  = LOAD_STALL_CYCLES > 1;

    hz_state_e   state_q, state_d;
    hz_state_e   ret_q, ret_d;
    hz_state_e   eff_state;
    logic [2:0]  lu_cnt_q, lu_cnt_d;
    hz_ctrl_t    ctrl;
    logic        lu, freeze;

    assign lu = idex_mem_read
             && idex_reg_rt != REG_ADDR_W'(ZERO_REG)
             && (idex_reg_rt == ifid_reg_rs
                 || (ifid_uses_rt && idex_reg_rt == ifid_reg_rt));

    assign freeze = exmem_mem_req && !dmem_ready;

    // While frozen, decisions resume from the state saved on entry.
    assign eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;

    always_comb begin
        ctrl     = CTRL_RUN;
        state_d  = state_q;
        ret_d    = ret_q;
        lu_cnt_d = lu_cnt_q;
        if (rst) begin
            ctrl     = CTRL_OFF;
            state_d  = RUN;
            ret_d    = RUN;
            lu_cnt_d = '0;
        end else if (freeze) begin
            ctrl    = CTRL_FREEZE;
            state_d = MEM_WAIT;
            ret_d   = eff_state;
        end else if (exmem_branch_taken) begin
            ctrl     = CTRL_BRANCH;
            state_d  = RUN;
            lu_cnt_d = '0;
        end else if (eff_state == LU_STALL) begin
            ctrl     = CTRL_STALL;
            lu_cnt_d = (lu_cnt_q == '0) ? '0 : lu_cnt_q - 3'd1;
            state_d  = (lu_cnt_q <= 3'd1) ? RUN : LU_STALL;
        end else if (lu) begin
            ctrl = CTRL_STALL;
            if (LU_MULTI) begin
                state_d  = LU_STALL;
                lu_cnt_d = LU_RELOAD;
            end else begin
                state_d = RUN;
            end
        end else begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            ret_q    <= RUN;
            lu_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            lu_cnt_q <= lu_cnt_d;
        end
    end

    assign {pc_write, ifid_write, ifid_flush, idex_write,
            idex_bubble, exmem_write, memwb_bubble, pc_redirect} = ctrl;

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_counters u_perf (
        .clk                  (clk),
        .rst                  (rst),
        .lu_bubble_i          (ctrl.idex_bubble & ~ctrl.ifid_flush),
        .flush_i              (ctrl.ifid_flush),
        .freeze_i             (ctrl.memwb_bubble),
        .perf_lu_bubbles_o    (perf_lu_bubbles),
        .perf_flushes_o       (perf_flushes),
        .perf_freeze_cycles_o (perf_freeze_cycles)
    );
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: two instances (2 and 3 load bubbles)
// checked against a remaining-bubble model every cycle plus literal checks.
module tb_hazard_stall_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs, rt, irt;
    logic       uses_rt, mem_read, br, mem_req, ready;

    logic [7:0] o2, o3;
    logic a0, a1, a2, a3, a4, a5, a6, a7;
    logic b0, b1, b2, b3, b4, b5, b6, b7;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [7:0] E_OFF = 8'b0000_0000;
    localparam logic [7:0] E_RUN = 8'b1101_0100;
    localparam logic [7:0] E_STL = 8'b0001_1100;
    localparam logic [7:0] E_BR  = 8'b1111_1101;
    localparam logic [7:0] E_FZ  = 8'b0000_0010;

    always #5 clk = ~clk;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] plu2, pfl2, pfz2, plu3, pfl3, pfz3;
`endif

    hazard_stall_controller #(.LOAD_STALL_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst),
        .ifid_reg_rs(rs), .ifid_reg_rt(rt), .ifid_uses_rt(uses_rt),
        .idex_mem_read(mem_read), .idex_reg_rt(irt),
        .exmem_branch_taken(br), .exmem_mem_req(mem_req),
        .dmem_ready(ready),
        .pc_write(a7), .ifid_write(a6), .ifid_flush(a5),
        .idex_write(a4), .idex_bubble(a3), .exmem_write(a2),
        .memwb_bubble(a1), .pc_redirect(a0)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_lu_bubbles(plu2), .perf_flushes(pfl2),
        .perf_freeze_cycles(pfz2)
`endif
    );

    hazard_stall_controller #(.LOAD_STALL_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst),
        .ifid_reg_rs(rs), .ifid_reg_rt(rt), .ifid_uses_rt(uses_rt),
        .idex_mem_read(mem_read), .idex_reg_rt(irt),
        .exmem_branch_taken(br), .exmem_mem_req(mem_req),
        .dmem_ready(ready),
        .pc_write(b7), .ifid_write(b6), .ifid_flush(b5),
        .idex_write(b4), .idex_bubble(b3), .exmem_write(b2),
        .memwb_bubble(b1), .pc_redirect(b0)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_lu_bubbles(plu3), .perf_flushes(pfl3),
        .perf_freeze_cycles(pfz3)
`endif
    );

    assign o2 = {a7, a6, a5, a4, a3, a2, a1, a0};
    assign o3 = {b7, b6, b5, b4, b3, b2, b1, b0};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", nm, act, exp,
                     $time);
        end
    endtask

    // Model: bubbles still owed per instance; freeze pauses everything.
    int          m_len [2] = '{2, 3};
    int          m_rem [2] = '{0, 0};
    int unsigned m_lu  [2] = '{0, 0};
    int unsigned m_fl  [2] = '{0, 0};
    int unsigned m_fz  [2] = '{0, 0};

    always @(negedge clk) begin
        logic [7:0] e, act;
        logic       fz, lu;
        fz = mem_req && !ready;
        lu = mem_read && irt != 5'd0 &&
             (irt == rs || (uses_rt && irt == rt));
        for (int k = 0; k < 2; k++) begin
`ifdef HAZARD_PERF_CNT_EN
            chk(k == 0 ? "perf_lu2" : "perf_lu3",
                k == 0 ? plu2 : plu3, m_lu[k]);
            chk(k == 0 ? "perf_fl2" : "perf_fl3",
                k == 0 ? pfl2 : pfl3, m_fl[k]);
            chk(k == 0 ? "perf_fz2" : "perf_fz3",
                k == 0 ? pfz2 : pfz3, m_fz[k]);
`endif
            if (rst) begin
                e = E_OFF;
                m_rem[k] = 0;
                m_lu[k] = 0;
                m_fl[k] = 0;
                m_fz[k] = 0;
            end else if (fz) begin
                e = E_FZ;
                m_fz[k]++;
            end else if (br) begin
                e = E_BR;
                m_rem[k] = 0;
                m_fl[k]++;
            end else if (m_rem[k] > 0) begin
                e = E_STL;
                m_rem[k]--;
                m_lu[k]++;
            end else if (lu) begin
                e = E_STL;
                m_rem[k] = m_len[k] - 1;
                m_lu[k]++;
            end else begin
                e = E_RUN;
            end
            act = (k == 0) ? o2 : o3;
            chk(k == 0 ? "model_o2" : "model_o3", {24'd0, act}, {24'd0, e});
        end
    end

    task automatic smp;
        @(negedge clk);
        #1;
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        rst = 0; rs = 5'd1; rt = 5'd2; irt = 5'd9; uses_rt = 0;
        mem_read = 0; br = 0; mem_req = 0; ready = 1;
    endtask

    initial begin
        idle();
        rst = 1;
        smp(); chk("reset_o2", {24'd0, o2}, {24'd0, E_OFF});
        chk("reset_o3", {24'd0, o3}, {24'd0, E_OFF});
        nxt();
        rst = 0;

        // no hazard
        for (int i = 0; i < 10; i++) begin
            smp(); if (i == 9) chk("idle_run", {24'd0, o2}, {24'd0, E_RUN});
            nxt();
        end

        // load-use, one cycle of match
        mem_read = 1; irt = 5'd5; rs = 5'd5;
        smp(); chk("lu_b1", {24'd0, o2}, {24'd0, E_STL}); nxt();
        mem_read = 0;
        smp(); chk("lu_b2", {24'd0, o2}, {24'd0, E_STL}); nxt();
        smp(); chk("lu_done2", {24'd0, o2}, {24'd0, E_RUN});
        chk("lu_b3_l3", {24'd0, o3}, {24'd0, E_STL}); nxt();
        smp(); chk("lu_done3", {24'd0, o3}, {24'd0, E_RUN}); nxt();

        // x0 destination never stalls
        mem_read = 1; irt = 5'd0; rs = 5'd0;
        smp(); chk("lu_zero", {24'd0, o2}, {24'd0, E_RUN}); nxt();
        idle();
        smp(); nxt();

        // branch beats load-use on rt
        mem_read = 1; irt = 5'd7; rt = 5'd7; rs = 5'd3; uses_rt = 1;
        br = 1;
        smp(); chk("br_vs_lu", {24'd0, o2}, {24'd0, E_BR}); nxt();
        idle();
        smp(); chk("br_after", {24'd0, o2}, {24'd0, E_RUN}); nxt();

        // rt match ignored without uses_rt
        mem_read = 1; irt = 5'd7; rt = 5'd7; rs = 5'd3; uses_rt = 0;
        smp(); chk("lu_imm", {24'd0, o2}, {24'd0, E_RUN}); nxt();
        idle();

        // memory freeze, branch held across it
        mem_req = 1; ready = 0;
        smp(); chk("fz1", {24'd0, o2}, {24'd0, E_FZ}); nxt();
        br = 1;
        smp(); chk("fz2_br", {24'd0, o2}, {24'd0, E_FZ}); nxt();
        smp(); chk("fz3_br", {24'd0, o2}, {24'd0, E_FZ}); nxt();
        ready = 1;
        smp(); chk("fz_ready_br", {24'd0, o2}, {24'd0, E_BR}); nxt();
        idle();
        smp(); chk("fz_after", {24'd0, o2}, {24'd0, E_RUN}); nxt();

        // same-cycle ready: no freeze
        mem_req = 1; ready = 1;
        smp(); chk("req_ready", {24'd0, o2}, {24'd0, E_RUN}); nxt();
        idle();

        // freeze inside a 3-bubble stall
        mem_read = 1; irt = 5'd4; rs = 5'd4;
        smp(); chk("s5_b1", {24'd0, o3}, {24'd0, E_STL}); nxt();
        mem_read = 0; mem_req = 1; ready = 0;
        smp(); chk("s5_fz1", {24'd0, o3}, {24'd0, E_FZ}); nxt();
        smp(); chk("s5_fz2", {24'd0, o3}, {24'd0, E_FZ}); nxt();
        mem_req = 0; ready = 1;
        smp(); chk("s5_b2", {24'd0, o3}, {24'd0, E_STL}); nxt();
        smp(); chk("s5_b3", {24'd0, o3}, {24'd0, E_STL});
        chk("s5_o2_run", {24'd0, o2}, {24'd0, E_RUN}); nxt();
        smp(); chk("s5_run", {24'd0, o3}, {24'd0, E_RUN}); nxt();

        // reset mid-stall
        mem_read = 1; irt = 5'd6; rs = 5'd6;
        smp(); chk("s5r_b1", {24'd0, o3}, {24'd0, E_STL}); nxt();
        mem_read = 0; rst = 1;
        smp(); chk("s5r_rst", {24'd0, o3}, {24'd0, E_OFF}); nxt();
        rst = 0;
        smp(); chk("s5r_run", {24'd0, o3}, {24'd0, E_RUN}); nxt();

`ifdef HAZARD_PERF_CNT_EN
        rst = 1;
        smp(); nxt();
        rst = 0;
        mem_read = 1; irt = 5'd5; rs = 5'd5;
        smp(); nxt();
        mem_read = 0;
        smp(); nxt();
        smp(); nxt();
        mem_req = 1; ready = 0;
        smp(); nxt();
        br = 1;
        smp(); nxt();
        smp(); nxt();
        ready = 1;
        smp(); nxt();
        idle();
        smp();
        chk("p6_lu", plu2, 32'd2);
        chk("p6_fz", pfz2, 32'd3);
        chk("p6_fl", pfl2, 32'd1);
        nxt();
`endif

        smp();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
